// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine; drives the req/gnt/rvalid data-memory port,
// steers store lanes and extracts/extends load data while stalling the pipeline.
module mem_access_unit #(
    parameter int DATA_W       = 32,
    parameter int LW_TYPE_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       MEM_ALUout,
    input  logic [DATA_W-1:0]       MEM_forward_rs2_data,
    input  logic                    MEM_Memread,
    input  logic                    MEM_Memwrite,
    input  logic [LW_TYPE_BITS-1:0] MEM_lw_type,
    input  logic [LW_TYPE_BITS-1:0] MEM_sw_type,
    input  logic                    MEM_flush,
    input  logic                    pipe_advance,
    output logic                    dm_req,
    output logic                    dm_we,
    output logic [DATA_W-1:0]       dm_addr,
    output logic [DATA_W/8-1:0]     dm_be,
    output logic [DATA_W-1:0]       dm_wdata,
    input  logic                    dm_gnt,
    input  logic                    dm_rvalid,
    input  logic [DATA_W-1:0]       dm_rdata,
    output logic                    mem_stall,
    output logic [DATA_W-1:0]       ld_data,
    output logic                    ld_valid,
    output logic                    mem_misalign
);
    localparam int NB = DATA_W / 8;
    localparam logic [LW_TYPE_BITS-1:0] T_HS = LW_TYPE_BITS'(1);
    localparam logic [LW_TYPE_BITS-1:0] T_BS = LW_TYPE_BITS'(2);
    localparam logic [LW_TYPE_BITS-1:0] T_HU = LW_TYPE_BITS'(3);
    localparam logic [LW_TYPE_BITS-1:0] T_BU = LW_TYPE_BITS'(4);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       addr_q, addr_d, wdata_q, wdata_d, ld_data_q, ld_data_d;
    logic [NB-1:0]           be_q, be_d;
    logic [LW_TYPE_BITS-1:0] lt_q, lt_d;
    logic [1:0]              off_q, off_d;
    logic                    we_q, we_d, ld_valid_q, ld_valid_d, mis_q, mis_d, kill_q, kill_d;

    logic              access, is_st, st_half, st_byte, ld_half, ld_byte, misaligned;
    logic [1:0]        off;
    logic [NB-1:0]     be_n;
    logic [DATA_W-1:0] wdata_n, ext;
    logic [15:0]       lane;

    assign access     = (MEM_Memread | MEM_Memwrite) & ~MEM_flush;
    assign is_st      = MEM_Memwrite;
    assign off        = MEM_ALUout[1:0];
    assign st_half    = MEM_sw_type == T_HS;
    assign st_byte    = MEM_sw_type == T_BS;
    assign ld_half    = MEM_lw_type == T_HS || MEM_lw_type == T_HU;
    assign ld_byte    = MEM_lw_type == T_BS || MEM_lw_type == T_BU;
    assign misaligned = (is_st ? st_half : ld_half) ? off[0] :
                        (is_st ? st_byte : ld_byte) ? 1'b0 : off != 2'b00;
    assign be_n       = !is_st ? '1 : st_byte ? NB'(1) << off :
                        st_half ? NB'(3) << {off[1], 1'b0} : '1;
    assign wdata_n    = !is_st ? '0 : st_byte ? {NB{MEM_forward_rs2_data[7:0]}} :
                        st_half ? {(NB/2){MEM_forward_rs2_data[15:0]}} : MEM_forward_rs2_data;

    // Aligned halves sit at off 0 or 2, so one byte-granular shift serves both sizes.
    assign lane = 16'(dm_rdata >> {off_q, 3'b000});
    assign ext  = lt_q == T_HS ? {{(DATA_W-16){lane[15]}}, lane} :
                  lt_q == T_BS ? {{(DATA_W-8){lane[7]}}, lane[7:0]} :
                  lt_q == T_HU ? {{(DATA_W-16){1'b0}}, lane} :
                  lt_q == T_BU ? {{(DATA_W-8){1'b0}}, lane[7:0]} : dm_rdata;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        lt_d       = lt_q;
        off_d      = off_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = ld_valid_q;
        kill_d     = kill_q;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: if (access) begin
                kill_d = 1'b0;
                if (misaligned) begin
                    state_d   = DONE;
                    mis_d     = 1'b1;
                    ld_data_d = '0;
                end else begin
                    state_d = REQ;
                    addr_d  = {MEM_ALUout[DATA_W-1:2], 2'b00};
                    we_d    = is_st;
                    be_d    = be_n;
                    wdata_d = wdata_n;
                    lt_d    = MEM_lw_type;
                    off_d   = off;
                end
            end
            REQ: if (dm_gnt) begin
                // A granted load must still drain its response even if flushed alongside the grant.
                state_d = !we_q ? WAIT : MEM_flush ? IDLE : DONE;
                kill_d  = MEM_flush;
            end else if (MEM_flush) begin
                state_d = IDLE;
            end
            WAIT: begin
                kill_d = kill_q | MEM_flush;
                if (dm_rvalid) begin
                    state_d = kill_d ? IDLE : DONE;
                    if (!kill_d) begin
                        ld_data_d  = ext;
                        ld_valid_d = 1'b1;
                    end
                end
            end
            DONE: if (pipe_advance) begin
                state_d    = IDLE;
                ld_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            lt_q       <= '0;
            off_q      <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            lt_q       <= lt_d;
            off_q      <= off_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            mis_q      <= mis_d;
            kill_q     <= kill_d;
        end
    end

    assign dm_req       = state_q == REQ;
    assign dm_we        = we_q;
    assign dm_addr      = addr_q;
    assign dm_be        = be_q;
    assign dm_wdata     = wdata_q;
    assign ld_data      = ld_data_q;
    assign ld_valid     = ld_valid_q;
    assign mem_misalign = mis_q;
    assign mem_stall    = state_q == IDLE ? access & rst : state_q != DONE;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed loads/stores against a byte-lane reference model,
// with a memory responder and a scoreboard monitor on the request port and completion.
module tb_mem_access_unit;
    logic        clk = 0, rst = 0;
    logic [31:0] MEM_ALUout = 0, MEM_forward_rs2_data = 0, dm_rdata = 0;
    logic [2:0]  MEM_lw_type = 0, MEM_sw_type = 0;
    logic        MEM_Memread = 0, MEM_Memwrite = 0, MEM_flush = 0, pipe_advance = 0;
    logic        dm_gnt = 0, dm_rvalid = 0;
    logic        dm_req, dm_we, mem_stall, ld_valid, mem_misalign;
    logic [31:0] dm_addr, dm_wdata, ld_data;
    logic [3:0]  dm_be;

    typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;} req_t;
    typedef struct {logic mis; logic vld; logic [31:0] data;} cmp_t;

    req_t        req_q[$];
    cmp_t        cmp_q[$];
    cmp_t        mc;
    int          tests = 0, fails = 0, mis_cnt = 0;
    int          gnt_cnt = 0, rv_dly = 0, rv_cnt = 0;
    logic        gnt_we = 0;
    logic [31:0] cur_rdata = 0, last_ld = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .MEM_ALUout(MEM_ALUout), .MEM_forward_rs2_data(MEM_forward_rs2_data),
        .MEM_Memread(MEM_Memread), .MEM_Memwrite(MEM_Memwrite), .MEM_lw_type(MEM_lw_type),
        .MEM_sw_type(MEM_sw_type), .MEM_flush(MEM_flush), .pipe_advance(pipe_advance),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
        .ld_data(ld_data), .ld_valid(ld_valid), .mem_misalign(mem_misalign)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference: access size in bytes, alignment by modulo, lanes by byte replication.
    function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] rs2,
                                  input logic [31:0] rdata, input logic [2:0] lt, input logic [2:0] swt,
                                  output req_t r, output cmp_t c);
        int sz, off;
        logic sgn;
        logic [31:0] mask, v;
        off  = int'(addr[1:0]);
        sz   = wr ? (swt == 1 ? 2 : swt == 2 ? 1 : 4) : (lt inside {1, 3} ? 2 : lt inside {2, 4} ? 1 : 4);
        sgn  = !wr && (lt inside {1, 2});
        mask = sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
        v    = (rdata >> (8 * off)) & mask;
        if (sgn && v[8*sz-1]) v = v | ~mask;
        r.addr = addr & ~32'd3;
        r.we   = wr;
        r.be   = wr ? 4'(((1 << sz) - 1) << off) : 4'hF;
        for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = rs2[8*(i % sz) +: 8];
        c.mis  = (off % sz) != 0;
        c.vld  = !wr && !c.mis;
        c.data = c.mis ? 32'd0 : wr ? last_ld : v;
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input logic [2:0] lt, input logic [2:0] swt,
                          input int gd, input int rvd, input int hold);
        req_t r;
        cmp_t c;
        int   n;
        model(wr, addr, rs2, rdata, lt, swt, r, c);
        if (!c.mis) req_q.push_back(r);
        cmp_q.push_back(c);
        if (c.mis || !wr) last_ld = c.data;
        MEM_Memread = rd; MEM_Memwrite = wr; MEM_ALUout = addr; MEM_forward_rs2_data = rs2;
        MEM_lw_type = lt; MEM_sw_type = swt;
        gnt_cnt = gd; rv_dly = rvd; cur_rdata = rdata;
        n = 0;
        do begin @(negedge clk); n++; end while (mem_stall && n < 64);
        chk("stall_release", 32'(mem_stall), 0);
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 pipe_advance = 1;
        @(posedge clk); #1 pipe_advance = 0; MEM_Memread = 0; MEM_Memwrite = 0;
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_dm_req"}, 32'(dm_req), 0);
        chk({t, "_dm_we"}, 32'(dm_we), 0);
        chk({t, "_dm_be"}, 32'(dm_be), 0);
        chk({t, "_dm_addr"}, dm_addr, 0);
        chk({t, "_dm_wdata"}, dm_wdata, 0);
        chk({t, "_ld_data"}, ld_data, 0);
        chk({t, "_ld_valid"}, 32'(ld_valid), 0);
        chk({t, "_misalign"}, 32'(mem_misalign), 0);
        chk({t, "_stall"}, 32'(mem_stall), 0);
    endtask

    // Memory responder: grant after gnt_cnt request cycles, read data rv_dly cycles after grant.
    always begin
        @(posedge clk); #1;
        if (dm_gnt && !gnt_we) rv_cnt = rv_dly + 1;
        dm_rvalid = 0;
        if (rv_cnt > 0) begin rv_cnt--; dm_rvalid = rv_cnt == 0; end
        dm_rdata = dm_rvalid ? cur_rdata : $urandom;
        dm_gnt = 0;
        if (dm_req) begin
            if (gnt_cnt == 0) begin dm_gnt = 1; gnt_we = dm_we; end
            else gnt_cnt--;
        end
    end

    always @(negedge clk) begin
        if (mem_misalign) mis_cnt++;
        if (dm_req) begin
            if (req_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_req: got addr %h with no request expected", dm_addr);
            end else begin
                chk("dm_addr", dm_addr, req_q[0].addr);
                chk("dm_we", 32'(dm_we), 32'(req_q[0].we));
                chk("dm_be", 32'(dm_be), 32'(req_q[0].be));
                if (req_q[0].we) chk("dm_wdata", dm_wdata, req_q[0].wdata);
                if (dm_gnt || MEM_flush) void'(req_q.pop_front());
            end
        end
        if ((MEM_Memread || MEM_Memwrite) && !mem_stall && pipe_advance) begin
            if (cmp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got completion with none expected");
            end else begin
                mc = cmp_q.pop_front();
                chk("misalign_pulses", 32'(mis_cnt), 32'(mc.mis));
                chk("ld_valid", 32'(ld_valid), 32'(mc.vld));
                chk("ld_data", ld_data, mc.data);
                mis_cnt = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : drv
        req_t r;
        cmp_t c;
        logic rd, wr;
        logic [31:0] addr;
        repeat (2) @(posedge clk);
        #1 MEM_Memread = 1; MEM_ALUout = 32'h100;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 MEM_Memread = 0; rst = 1;
        @(posedge clk); #1;
        run_op(1, 0, 32'h103, 0, 32'h80FF1234, 3'd2, 0, 0, 0, 0);
        run_op(1, 0, 32'h202, 0, 32'hBEEF0000, 3'd3, 0, 0, 0, 1);
        run_op(0, 1, 32'h31, 32'hA5, 0, 0, 3'd2, 3, 0, 0);
        run_op(0, 1, 32'h42, 32'h12345678, 0, 0, 3'd0, 0, 0, 0);
        run_op(1, 1, 32'h86, 32'h0000C3D2, 32'hFFFF_FFFF, 3'd0, 3'd1, 1, 0, 2);

        // flush while the request waits for its grant
        model(0, 32'h500, 0, 0, 3'd0, 0, r, c);
        req_q.push_back(r);
        MEM_ALUout = 32'h500; MEM_lw_type = 0; MEM_Memread = 1; gnt_cnt = 3; rv_dly = 0;
        @(posedge clk); #1 MEM_flush = 1;
        @(posedge clk); #1 MEM_flush = 0; MEM_Memread = 0;
        repeat (2) begin
            @(negedge clk);
            chk("flush_req_dm_req", 32'(dm_req), 0);
            chk("flush_req_stall", 32'(mem_stall), 0);
            chk("flush_req_ld_valid", 32'(ld_valid), 0);
        end

        // flush while the read response is outstanding
        @(posedge clk); #1;
        model(0, 32'h604, 0, 0, 3'd2, 0, r, c);
        req_q.push_back(r);
        MEM_ALUout = 32'h604; MEM_lw_type = 3'd2; MEM_Memread = 1; gnt_cnt = 0; rv_dly = 2; cur_rdata = 32'h7F7F7F7F;
        @(posedge clk); #1;
        @(posedge clk); #1 MEM_flush = 1; MEM_Memread = 0;
        @(negedge clk);
        chk("flush_wait_stall", 32'(mem_stall), 1);
        @(posedge clk); #1 MEM_flush = 0;
        repeat (4) @(negedge clk);
        chk("flush_wait_stall_after", 32'(mem_stall), 0);
        chk("flush_wait_ld_valid", 32'(ld_valid), 0);
        chk("flush_wait_ld_data", ld_data, last_ld);

        // reset in the middle of a read, response arrives afterwards
        @(posedge clk); #1;
        model(0, 32'h700, 0, 0, 3'd0, 0, r, c);
        req_q.push_back(r);
        MEM_ALUout = 32'h700; MEM_lw_type = 0; MEM_Memread = 1; gnt_cnt = 0; rv_dly = 3; cur_rdata = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 0; MEM_Memread = 0;
        @(negedge clk);
        chk_zero("rst_wait");
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        repeat (2) @(negedge clk);
        chk_zero("rst_after_rvalid");
        last_ld = 0;
        @(posedge clk); #1;

        repeat (250) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1;
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_op(rd, wr, addr, $urandom, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        repeat (3) @(negedge clk);
        chk("req_queue_drained", 32'(req_q.size()), 0);
        chk("cmp_queue_drained", 32'(cmp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
